// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII framers: state encodings, preamble/SFD
// bytes, default frame limits and the byte-count width.
// No ports; imported by gmii_rx and gmii_rx_capture.
package gmii_pkg;

    localparam int CNT_W = 11;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam logic [CNT_W-1:0] P_MINLEN_DEF = 11'd64;
    localparam logic [CNT_W-1:0] P_MAXLEN_DEF = 11'd1522;
    localparam logic [3:0]       P_MAXPRE_DEF = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREA = 3'd1,
        ST_BDY  = 3'd2,
        ST_DROP = 3'd3,
        ST_END  = 3'd4
    } gmii_state_e;

    function automatic logic [7:0] nib_swap(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

endpackage

// File: rtl/gmii_rx_capture.sv
// Input capture for the GMII receive framer. Registers RXD/RXDV/RXER and
// keeps the "armed" flag that gates frame starts after reset.
// Optional macro GMII_RX_NIBBLE_SWAP_EN: store RXD with its nibbles swapped.
// Ports:
//   clk_i, rst_i            receive clock, async active-high reset
//   rxd_i, rxdv_i, rxer_i   raw GMII receive bus
//   rxd_o, rxdv_o, rxer_o   captured bus
//   armed_o                 a frame may start (RXDV seen low since reset)
module gmii_rx_capture
    import gmii_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rxd_i,
    input  logic       rxdv_i,
    input  logic       rxer_i,
    output logic [7:0] rxd_o,
    output logic       rxdv_o,
    output logic       rxer_o,
    output logic       armed_o
);

    logic [7:0] rxd_q;
    logic       rxdv_q;
    logic       rxer_q;
    logic       armed_q;
    logic [7:0] rxd_d;

`ifdef GMII_RX_NIBBLE_SWAP_EN
    assign rxd_d = nib_swap(rxd_i);
`else
    assign rxd_d = rxd_i;
`endif

    // armed_q follows the raw RXDV so it becomes set on the same edge that
    // captures RXDV=0; keying off the reset value of rxdv_q would arm the
    // block immediately after reset and accept a frame already in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_q   <= 8'h00;
            rxdv_q  <= 1'b0;
            rxer_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            rxd_q   <= rxd_d;
            rxdv_q  <= rxdv_i;
            rxer_q  <= rxer_i;
            armed_q <= armed_q | ~rxdv_i;
        end
    end

    assign rxd_o   = rxd_q;
    assign rxdv_o  = rxdv_q;
    assign rxer_o  = rxer_q;
    assign armed_o = armed_q;

endmodule

// File: rtl/gmii_rx.sv
// Receive-side GMII framer. Strips preamble/SFD, writes body bytes (FCS
// included) into the packet FIFO and, at frame end, commits the frame with
// its byte count or asks the FIFO to rewind.
// Optional macro GMII_RX_NIBBLE_SWAP_EN (handled in gmii_rx_capture).
// Ports:
//   ARST, RCLK                      async active-high reset, receive clock
//   RXD, RXDV, RXER                 GMII receive bus
//   FIFO_FULL                       FIFO cannot take a write this cycle
//   FIFO_WDAT, FIFO_WEN             body byte and write strobe
//   FIFO_WCNT                       byte count of the frame just ended
//   FIFO_WVALID, FIFO_WDROP         one-cycle commit / discard pulses
module gmii_rx
    import gmii_pkg::*;
#(
    parameter logic [CNT_W-1:0] P_MINLEN = P_MINLEN_DEF,
    parameter logic [CNT_W-1:0] P_MAXLEN = P_MAXLEN_DEF,
    parameter logic [3:0]       P_MAXPRE = P_MAXPRE_DEF
) (
    input  logic             ARST,
    input  logic             RCLK,
    input  logic [7:0]       RXD,
    input  logic             RXDV,
    input  logic             RXER,
    input  logic             FIFO_FULL,
    output logic [7:0]       FIFO_WDAT,
    output logic             FIFO_WEN,
    output logic [CNT_W-1:0] FIFO_WCNT,
    output logic             FIFO_WVALID,
    output logic             FIFO_WDROP
);

    logic [7:0] r_rxd;
    logic       r_rxdv;
    logic       r_rxer;
    logic       r_armed;

    gmii_rx_capture u_cap (
        .clk_i   (RCLK),
        .rst_i   (ARST),
        .rxd_i   (RXD),
        .rxdv_i  (RXDV),
        .rxer_i  (RXER),
        .rxd_o   (r_rxd),
        .rxdv_o  (r_rxdv),
        .rxer_o  (r_rxer),
        .armed_o (r_armed)
    );

    gmii_state_e      state_q;
    logic [4:0]       precnt_q;
    logic [CNT_W-1:0] r_bcnt;
    logic             err_q;
    logic             ovf_q;
    logic [7:0]       wdat_q;
    logic             wen_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             wvalid_q;
    logic             wdrop_q;

    // Preamble byte evaluation, shared by IDLE (first byte of a frame) and
    // PREA. The count is one wider than P_MAXPRE so "exceeds" is reachable.
    logic [4:0]  pre_base;
    logic [4:0]  precnt_d;
    gmii_state_e pre_state_d;

    always_comb begin
        pre_base    = (state_q == ST_IDLE) ? 5'd0 : precnt_q;
        precnt_d    = (pre_base == 5'h1F) ? pre_base : pre_base + 5'd1;
        pre_state_d = ST_DROP;
        if (r_rxd == SFD_BYTE)
            pre_state_d = ST_BDY;
        else if (r_rxd == PRE_BYTE && precnt_d <= {1'b0, P_MAXPRE})
            pre_state_d = ST_PREA;
    end

    always_ff @(posedge RCLK or posedge ARST) begin
        if (ARST) begin
            state_q  <= ST_IDLE;
            precnt_q <= 5'd0;
            r_bcnt   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wdat_q   <= 8'h00;
            wen_q    <= 1'b0;
            wcnt_q   <= '0;
            wvalid_q <= 1'b0;
            wdrop_q  <= 1'b0;
        end else begin
            wen_q    <= 1'b0;
            wvalid_q <= 1'b0;
            wdrop_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (r_rxdv) begin
                        r_bcnt <= '0;
                        err_q  <= 1'b0;
                        ovf_q  <= 1'b0;
                        if (!r_armed) begin
                            state_q <= ST_DROP;
                        end else begin
                            state_q  <= pre_state_d;
                            precnt_q <= precnt_d;
                        end
                    end
                end
                ST_PREA: begin
                    if (!r_rxdv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= pre_state_d;
                        precnt_q <= precnt_d;
                    end
                end
                ST_BDY: begin
                    if (!r_rxdv) begin
                        state_q <= ST_END;
                    end else begin
                        if (r_rxer)
                            err_q <= 1'b1;
                        if (r_bcnt == P_MAXLEN) begin
                            // Overlength: the byte is not written and the
                            // frame is discarded once RXDV drops.
                            err_q   <= 1'b1;
                            state_q <= ST_DROP;
                        end else if (FIFO_FULL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wdat_q <= r_rxd;
                            wen_q  <= 1'b1;
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    // Only rewind the FIFO if this frame actually wrote
                    // something; routing through END keeps the pulse timing
                    // identical to the normal end-of-body path.
                    if (!r_rxdv)
                        state_q <= (r_bcnt != '0) ? ST_END : ST_IDLE;
                end
                ST_END: begin
                    if (!err_q && !ovf_q && r_bcnt >= P_MINLEN)
                        wvalid_q <= 1'b1;
                    else
                        wdrop_q <= 1'b1;
                    wcnt_q  <= r_bcnt;
                    r_bcnt  <= '0;
                    err_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign FIFO_WDAT   = wdat_q;
    assign FIFO_WEN    = wen_q;
    assign FIFO_WCNT   = wcnt_q;
    assign FIFO_WVALID = wvalid_q;
    assign FIFO_WDROP  = wdrop_q;

endmodule

// File: doc/gmii_rx.md
# gmii_rx

Receive-side GMII framer for the repeater. It takes the PHY receive bus on RCLK and strips preamble and SFD. Body bytes, including the FCS, are written into the packet FIFO. At the end of each frame it either commits the frame with its byte count or tells the FIFO to drop it. It is the producer that feeds the FIFO the transmit framer drains, and supplies the byte count that framer uses as its read count.

## Interface
- P_MINLEN, 11'd64: shortest frame committed, bytes after SFD including FCS.
- P_MAXLEN, 11'd1522: longest frame committed; the first byte beyond it forces a drop.
- P_MAXPRE, 4'd15: most 0x55 bytes accepted before SFD.
- ARST  in  1  asynchronous, active-high reset.
- RCLK  in  1  receive clock, 125 MHz.
- RXD  in  8  GMII receive data.
- RXDV  in  1  receive data valid.
- RXER  in  1  receive error.
- FIFO_FULL  in  1  FIFO cannot accept a write this cycle.
- FIFO_WDAT  out  8  body byte.
- FIFO_WEN  out  1  write strobe for FIFO_WDAT.
- FIFO_WCNT  out  11  bytes written for the frame just ended; valid with FIFO_WVALID or FIFO_WDROP.
- FIFO_WVALID  out  1  one-cycle pulse: commit frame.
- FIFO_WDROP  out  1  one-cycle pulse: discard the frame's written bytes (rewind to last commit).

## Operation
- Capture stage registers RXD, RXDV and RXER, giving r_rxd, r_rxdv and r_rxer. The FSM and all decisions use the captured values only.
- Flag r_armed resets to 0 and sets whenever r_rxdv=0. A frame may start only while it is set, so frames already in progress at reset release are ignored.
- States: ST_IDLE, ST_PREA, ST_BDY, ST_DROP, ST_END.
- ST_IDLE:
  - r_rxdv=1 and r_armed → ST_PREA.
  - r_rxdv=1 and not r_armed → ST_DROP.
- ST_PREA:
  - r_rxd=8'h55: increment the preamble count, which saturates.
  - r_rxd=8'hD5 → ST_BDY; zero preamble bytes is allowed.
  - Any other byte, or a preamble count exceeding P_MAXPRE → ST_DROP, no writes issued.
  - r_rxdv=0 → ST_IDLE, no pulse.
- ST_BDY, for each cycle with r_rxdv=1:
  - FIFO_FULL=0: FIFO_WDAT=r_rxd, FIFO_WEN=1, r_bcnt++.
  - FIFO_FULL=1: no write; set overflow flag.
  - r_rxer=1 sets the error flag.
  - r_bcnt would exceed P_MAXLEN: set the error flag and go to ST_DROP. That byte is not written.
- ST_BDY, when r_rxdv=0 → ST_END:
  - Commit (FIFO_WVALID) when no error flag, no overflow flag, and r_bcnt ≥ P_MINLEN.
  - Otherwise FIFO_WDROP.
  - FIFO_WCNT=r_bcnt in both cases.
- ST_DROP:
  - Stays until r_rxdv=0.
  - If any bytes were written in ST_BDY, emits FIFO_WDROP with FIFO_WCNT=r_bcnt.
  - Then → ST_IDLE.
- ST_END: emits the pulse, clears r_bcnt and the flags, then → ST_IDLE.
- r_bcnt is 11 bits. The P_MAXLEN check prevents wrap.

## Timing
- Reset values: FIFO_WDAT=8'h00, FIFO_WEN=0, FIFO_WCNT=0, FIFO_WVALID=0, FIFO_WDROP=0, FSM in ST_IDLE.
- Latency: a byte sampled on RXD at edge N appears on FIFO_WDAT/FIFO_WEN after edge N+1.
- RXDV sampled low at edge M: the commit/drop pulse is high for exactly one cycle after edge M+2.
- FIFO_WCNT updates with the pulse and holds until the next pulse.
- At most one pulse per frame. WVALID and WDROP are never high together.
- A new frame may begin at the second edge after the pulse; minimum IFG on the line is ≥ 8 cycles, so nothing is lost.
- FIFO_FULL and RXER in the same cycle: the byte is not written and the frame drops.
- RXER on the last byte: the frame drops.
- ARST mid-frame clears everything immediately. No pulse is emitted for the partial frame; the FIFO is reset by the same ARST.

## Configuration
- GMII_RX_NIBBLE_SWAP_EN defined: the capture stage stores {RXD[3:0],RXD[7:4]}. All preamble/SFD comparisons and FIFO_WDAT use the swapped byte. This matches the board wiring that the transmit side compensates for.
- GMII_RX_NIBBLE_SWAP_EN undefined: RXD is used unmodified.

## Structure
- Package gmii_pkg holds:
  - state encodings, shared with the transmit framer;
  - preamble byte 8'h55 and SFD byte 8'hD5;
  - default P_MINLEN, P_MAXLEN, P_MAXPRE;
  - the 11-bit count width.
- One sub-module: gmii_rx_capture. It contains the input registers, the optional nibble swap under the macro, and the r_armed flag.
- The FSM, counters and FIFO write logic stay in gmii_rx.

## Test plan
- 7×0x55, 0xD5, 64 body bytes 0x00..0x3F: 64 writes in order, FIFO_WVALID once, FIFO_WCNT=64.
- Same frame with RXER high on body byte 10: 64 writes, FIFO_WDROP once, FIFO_WCNT=64, no WVALID.
- 60-byte body: FIFO_WDROP, FIFO_WCNT=60.
- 1600-byte body: 1522 writes, then ST_DROP, FIFO_WDROP with FIFO_WCNT=1522.
- Preamble 0x55,0x55,0xAA: no writes, no pulse. A following valid 100-byte frame commits with FIFO_WCNT=100.
- ARST released while RXDV is high mid-frame: no writes until RXDV goes low. The next 64-byte frame commits.
- FIFO_FULL held for 3 cycles mid-body of a 100-byte frame: 97 writes, FIFO_WDROP with FIFO_WCNT=97.
- With GMII_RX_NIBBLE_SWAP_EN defined: RXD 0x55×7, 0x5D, body byte 0x21 → SFD detected, FIFO_WDAT=0x12.
